// File: rtl/prng_checker.sv
// prng_checker: self-synchronising checker for the x^32+x^7+x^5+x^3+x^2+x+1 Galois LFSR stream; PRNG_CHK_BITERR_EN adds bit_err_cnt
module prng_checker #(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [31:0]      din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRNG_CHK_BITERR_EN
    ,
    output logic [CNT_W-1:0] bit_err_cnt
`endif
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(LOSS_N + 1);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_N);
    localparam logic [BW-1:0] LOSS_C = BW'(LOSS_N);
    typedef enum logic {SEEK, LOCKED} state_t;
    state_t        state;
    logic [31:0]   ref_q;
    logic [31:0]   pred;
    logic          ref_ok;
    logic [GW-1:0] good_run;
    logic [BW-1:0] bad_run;
    logic          hit;
    logic          miss;
    assign pred   = {ref_q[30:0], 1'b0} ^ (ref_q[31] ? 32'h0000_00AF : 32'h0);
    assign hit    = din == pred;
    assign miss   = din_valid && state == LOCKED && !hit;
    assign locked = state == LOCKED;
`ifdef PRNG_CHK_BITERR_EN
    logic [31:0]      diff;
    logic [5:0]       pop;
    logic [CNT_W+5:0] bsum;
    logic [CNT_W-1:0] bsat;
    assign diff = din ^ pred;
    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) pop = pop + 6'(diff[i]);
    end
    assign bsum = (CNT_W+6)'(bit_err_cnt) + (CNT_W+6)'(pop);
    assign bsat = |bsum[CNT_W+5:CNT_W] ? '1 : bsum[CNT_W-1:0];
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) bit_err_cnt <= '0;
        else if (din_valid && state == LOCKED) bit_err_cnt <= bsat;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEEK;
            ref_q    <= '0;
            ref_ok   <= 1'b0;
            good_run <= '0;
            bad_run  <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err <= miss;
            if (clr_cnt) err_cnt <= '0;
            else if (miss && ~&err_cnt) err_cnt <= err_cnt + 1'b1;
            if (din_valid && state == SEEK) begin
                if (din == '0) begin
                    good_run <= '0;
                    ref_ok   <= 1'b0;
                end else begin
                    ref_q  <= din;
                    ref_ok <= 1'b1;
                    if (ref_ok && hit) begin
                        good_run <= good_run + 1'b1;
                        if (good_run + 1'b1 == LOCK_C) begin
                            state   <= LOCKED;
                            bad_run <= '0;
                        end
                    end else good_run <= '0;
                end
            end else if (din_valid) begin
                // free-run on the prediction so a single corrupted word is counted once
                ref_q <= pred;
                if (hit) bad_run <= '0;
                else begin
                    bad_run <= bad_run + 1'b1;
                    if (bad_run + 1'b1 == LOSS_C) begin
                        state    <= SEEK;
                        good_run <= '0;
                        ref_q    <= din;
                        ref_ok   <= din != '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_prng_checker.sv
// tb_prng_checker: table, directed and random checks of prng_checker against a behavioural model
module tb_prng_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [31:0] din = '0;
    logic        locked, err, locked_s, err_s;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt_s;
`ifdef PRNG_CHK_BITERR_EN
    logic [15:0] bit_err_cnt;
    logic [3:0]  bit_err_cnt_s;
`endif
    int vecs = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prng_checker dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_cnt(err_cnt)
`ifdef PRNG_CHK_BITERR_EN
        , .bit_err_cnt(bit_err_cnt)
`endif
    );

    prng_checker #(.LOCK_N(4), .LOSS_N(32), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
        .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s)
`ifdef PRNG_CHK_BITERR_EN
        , .bit_err_cnt(bit_err_cnt_s)
`endif
    );

    int          m_lock_n[2] = '{4, 4};
    int          m_loss_n[2] = '{8, 32};
    int          m_w[2]      = '{16, 4};
    bit          m_locked[2], m_have[2], m_err[2];
    logic [31:0] m_last[2];
    int          m_good[2], m_bad[2], m_cnt[2], m_bcnt[2];

    function automatic logic [31:0] nxt(logic [31:0] d);
        return d[31] ? ((d << 1) ^ 32'h0000_00AF) : (d << 1);
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        vecs++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model(int k, bit r, bit v, logic [31:0] d, bit c);
        int cap = (1 << m_w[k]) - 1;
        int e = 0;
        int b = 0;
        logic [31:0] p;
        if (r) begin
            m_locked[k] = 0; m_have[k] = 0; m_err[k] = 0; m_last[k] = 0;
            m_good[k] = 0; m_bad[k] = 0; m_cnt[k] = 0; m_bcnt[k] = 0;
            return;
        end
        m_err[k] = 0;
        if (v && !m_locked[k]) begin
            if (d == 0) begin
                m_good[k] = 0; m_have[k] = 0;
            end else begin
                if (m_have[k] && d == nxt(m_last[k])) begin
                    m_good[k]++;
                    if (m_good[k] == m_lock_n[k]) begin m_locked[k] = 1; m_bad[k] = 0; end
                end else m_good[k] = 0;
                m_last[k] = d; m_have[k] = 1;
            end
        end else if (v) begin
            p = nxt(m_last[k]);
            m_last[k] = p;
            b = $countones(d ^ p);
            if (d == p) m_bad[k] = 0;
            else begin
                m_err[k] = 1; e = 1; m_bad[k]++;
                if (m_bad[k] == m_loss_n[k]) begin
                    m_locked[k] = 0; m_good[k] = 0; m_last[k] = d; m_have[k] = d != 0;
                end
            end
        end
        m_cnt[k]  = c ? 0 : (m_cnt[k] + e > cap ? cap : m_cnt[k] + e);
        m_bcnt[k] = c ? 0 : (m_bcnt[k] + b > cap ? cap : m_bcnt[k] + b);
    endtask

    task automatic cyc(bit r, bit v, logic [31:0] d, bit c);
        rst = r; din_valid = v; din = d; clr_cnt = c;
        @(posedge clk);
        model(0, r, v, d, c);
        model(1, r, v, d, c);
        @(negedge clk);
        chk("locked", 32'(locked), 32'(m_locked[0]));
        chk("err", 32'(err), 32'(m_err[0]));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt[0]));
        chk("locked_s", 32'(locked_s), 32'(m_locked[1]));
        chk("err_s", 32'(err_s), 32'(m_err[1]));
        chk("err_cnt_s", 32'(err_cnt_s), 32'(m_cnt[1]));
`ifdef PRNG_CHK_BITERR_EN
        chk("bit_err_cnt", 32'(bit_err_cnt), 32'(m_bcnt[0]));
        chk("bit_err_cnt_s", 32'(bit_err_cnt_s), 32'(m_bcnt[1]));
`endif
    endtask

    typedef struct {
        bit          r;
        bit          v;
        logic [31:0] d;
        bit          el;
        bit          ee;
        logic [15:0] ec;
    } vec_t;

    initial begin
        vec_t        tbl[10];
        logic [31:0] w;
        logic [31:0] tx;
        int          rn;
        tbl[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 32'h1,   1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 32'h2,   1'b0, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 32'h4,   1'b0, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 32'h8,   1'b0, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b1, 32'h10,  1'b1, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 1'b1, 32'h20,  1'b1, 1'b0, 16'd0};
        tbl[7] = '{1'b0, 1'b1, 32'h41,  1'b1, 1'b1, 16'd1};
        tbl[8] = '{1'b0, 1'b1, 32'h80,  1'b1, 1'b0, 16'd1};
        tbl[9] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 16'd1};
        chk("step_wrap", nxt(32'h8000_0000), 32'h0000_00AF);
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d, 1'b0);
            chk("tbl_locked", 32'(locked), 32'(tbl[i].el));
            chk("tbl_err", 32'(err), 32'(tbl[i].ee));
            chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].ec));
        end
`ifdef PRNG_CHK_BITERR_EN
        chk("tbl_bit_err_cnt", 32'(bit_err_cnt), 32'd1);
`endif
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 32'hDEAD_BEEF, 0);
        chk("loss_err_cnt", 32'(err_cnt), 32'd8);
        chk("loss_locked", 32'(locked), 32'd0);
        w = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, w, 0);
            w = nxt(w);
        end
        chk("relock", 32'(locked), 32'd1);
        cyc(1, 0, 0, 0);
        w = 32'h1;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, w, 0);
            w = nxt(w);
            cyc(0, 1, w, 0);
            cyc(0, 1, 32'h0, 0);
            w = nxt(w);
            chk("zero_nolock", 32'(locked), 32'd0);
            chk("zero_noerr", 32'(err), 32'd0);
        end
        cyc(1, 0, 0, 0);
        tx = 32'h1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, tx, 0);
            tx = nxt(tx);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, tx ^ 32'h3, 0);
            tx = nxt(tx);
        end
        chk("sat_err_cnt", 32'(err_cnt_s), 32'hF);
        chk("sat_locked", 32'(locked_s), 32'd1);
        cyc(0, 1, tx ^ 32'h3, 1);
        tx = nxt(tx);
        chk("clr_err", 32'(err_s), 32'd1);
        chk("clr_err_cnt", 32'(err_cnt_s), 32'd0);
        cyc(1, 0, 0, 0);
        tx = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, tx, 0);
            tx = nxt(tx);
            repeat (3) cyc(0, 0, 0, 0);
        end
        chk("gap_locked", 32'(locked), 32'd1);
        cyc(0, 1, tx ^ 32'h100, 0);
        tx = nxt(tx);
        chk("gap_err", 32'(err), 32'd1);
        repeat (3) cyc(0, 0, 0, 0);
        chk("gap_err_cnt", 32'(err_cnt), 32'd1);
        cyc(1, 0, 0, 0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        tx = 32'hACE1_0001;
        for (int i = 0; i < 600; i++) begin
            rn = int'($urandom_range(0, 99));
            if ($urandom_range(0, 149) == 0) cyc(1, 0, 0, 0);
            else if ($urandom_range(0, 9) < 3) cyc(0, 0, $urandom, $urandom_range(0, 29) == 0);
            else begin
                if (rn < 4) tx = $urandom;
                w = rn < 7 ? 32'h0 : rn < 15 ? tx ^ (32'h1 << $urandom_range(0, 31)) : tx;
                cyc(0, 1, w, $urandom_range(0, 29) == 0);
                tx = nxt(tx);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
